divider_24: RTL



---
 rtl/divider_24.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/divider_24.sv
// divider_24 -- iterative restoring mantissa divider for the FPU divide path.
// Produces Q = floor(D_inA * 2^25 / D_inB) (26 bits, bit 25 is the integer
// bit) and a sticky bit (final remainder nonzero) under a start/done handshake.
// Optional build macro: DIVIDER_24_RADIX4_EN -- chains two restoring steps per
// cycle (13 CALC cycles instead of 26); results are bit-identical.
module divider_24 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] D_inA,
  input  logic [23:0] D_inB,
  output logic        busy,
  output logic        done,
  output logic [25:0] Q,
  output logic        sticky,
  output logic        div_by_zero
);

`ifdef DIVIDER_24_RADIX4_EN
  localparam logic [4:0] LAST_CNT = 5'd12;
`else
  localparam logic [4:0] LAST_CNT = 5'd25;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [24:0] r_reg;
  logic [25:0] quo_reg;
  logic [4:0]  cnt_reg;
  logic [23:0] b_reg;
  logic        b_zero_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [25:0] q_out_reg;
  logic        sticky_reg;
  logic        dbz_reg;

  logic [24:0] r_next;
  logic [25:0] quo_next;
  logic [24:0] r_s1;
  logic [25:0] q_s1;
`ifdef DIVIDER_24_RADIX4_EN
  logic [24:0] r_s2;
  logic [25:0] q_s2;
`endif

  // One restoring step: conditional subtract, shift quotient bit in, then
  // shift the partial remainder left. R < 2*B <= 2^25 keeps it within 25 bits.
  function automatic logic [50:0] div_step(input logic [24:0] r,
                                           input logic [25:0] q,
                                           input logic [23:0] b);
    logic        ge;
    logic [24:0] diff;
    logic [24:0] r_sh;
    logic [25:0] q_sh;
    ge   = (r >= {1'b0, b});
    diff = ge ? (r - {1'b0, b}) : r;
    r_sh = diff << 1;
    q_sh = (q << 1) | {25'd0, ge};
    return {r_sh, q_sh};
  endfunction

  // Per-cycle iteration: one step, or two chained steps in the radix-4 build.
  always_comb begin
    r_s1     = '0;
    q_s1     = '0;
    r_next   = '0;
    quo_next = '0;
    {r_s1, q_s1} = div_step(r_reg, quo_reg, b_reg);
`ifdef DIVIDER_24_RADIX4_EN
    r_s2 = '0;
    q_s2 = '0;
    {r_s2, q_s2} = div_step(r_s1, q_s1, b_reg);
    r_next   = r_s2;
    quo_next = q_s2;
`else
    r_next   = r_s1;
    quo_next = q_s1;
`endif
  end

  // Control FSM with registered outputs; results are only written at the
  // final step so they hold through the next operation until its done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      r_reg      <= '0;
      quo_reg    <= '0;
      cnt_reg    <= '0;
      b_reg      <= '0;
      b_zero_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      q_out_reg  <= '0;
      sticky_reg <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            r_reg      <= {1'b0, D_inA};
            quo_reg    <= '0;
            cnt_reg    <= '0;
            b_reg      <= D_inB;
            b_zero_reg <= (D_inB == 24'd0);
            busy_reg   <= 1'b1;
            state_reg  <= CALC;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        CALC: begin
          r_reg   <= r_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == LAST_CNT) begin
            // A zero divisor still runs the full count so latency is fixed.
            q_out_reg  <= b_zero_reg ? 26'h3FFFFFF : quo_next;
            sticky_reg <= b_zero_reg | (r_next != 25'd0);
            dbz_reg    <= b_zero_reg;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= DONE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign Q           = q_out_reg;
  assign sticky      = sticky_reg;
  assign div_by_zero = dbz_reg;

endmodule
